// File: rtl/mem_intf_pkg.sv
// Shared types and default sizing for the execute-stage memory interface.
package mem_intf_pkg;

    localparam int unsigned DEF_ADDR_W    = 14;
    localparam int unsigned DEF_MEM_W     = 16;
    localparam int unsigned DEF_OP_W      = 8;
    localparam int unsigned DEF_CMD_DEPTH = 2;
    localparam int unsigned DEF_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                  is_write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_MEM_W-1:0]  data;
    } mem_cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Small command queue; pointers carry one extra bit to tell full from empty.
module mem_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = (AW == 0) ? 1 : AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign wr_idx  = (DEPTH == 1) ? '0 : IW'(wr_ptr);
    assign rd_idx  = (DEPTH == 1) ? '0 : IW'(rd_ptr);
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/mem_intf_ctrl.sv
// Load/store front end: queues commands, issues one SMM request at a time,
// returns the addressed operand lane and reports done / error pulses.
module mem_intf_ctrl
    import mem_intf_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MEM_W     = DEF_MEM_W,
    parameter int unsigned OP_W      = DEF_OP_W,
    parameter int unsigned CMD_DEPTH = DEF_CMD_DEPTH,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MEM_W-1:0]  result,
    output logic              cmd_ready,
    output logic              mem_done,
    output logic              mem_err,
    output logic [OP_W-1:0]   datatoinst,
    output logic              read_req,
    output logic              write_req,
    output logic [ADDR_W-1:0] addrout,
    output logic [MEM_W-1:0]  wdata,
    input  logic [MEM_W-1:0]  rdata,
    input  logic              mem_resp
);

    localparam int unsigned NLANE = MEM_W / OP_W;
    localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [MEM_W-1:0]  data;
    } cmd_t;

    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       push;
    logic       pop;
    logic       rej;
    logic       full;
    logic       empty;
    logic [31:0] lane_sel;
    logic [OP_W-1:0] lane_data;

    mem_state_e        state, state_d;
    logic [CW-1:0]     wait_cnt, wait_cnt_d;
    logic              read_req_d, write_req_d, mem_done_d, mem_err_d;
    logic [ADDR_W-1:0] addrout_d;
    logic [MEM_W-1:0]  wdata_d;
    logic [OP_W-1:0]   datatoinst_d;

    assign cmd_ready = !full;
    assign push      = !full && (load ^ store);
    assign rej       = !full && load && store;
    assign push_cmd  = '{is_write: store, addr: addr, data: result};

    mem_cmd_fifo #(
        .WIDTH($bits(cmd_t)),
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (push_cmd),
        .dout   (head_cmd),
        .full   (full),
        .empty  (empty)
    );

    // Operand lane chosen by the low address bits of the held request.
    assign lane_sel  = 32'(addrout) % NLANE;
    assign lane_data = rdata[lane_sel*OP_W +: OP_W];

    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        read_req_d   = read_req;
        write_req_d  = write_req;
        addrout_d    = addrout;
        wdata_d      = wdata;
        datatoinst_d = datatoinst;
        mem_done_d   = 1'b0;
        mem_err_d    = rej;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    addrout_d  = head_cmd.addr;
                    wait_cnt_d = '0;
                    state_d    = REQ;
                    if (head_cmd.is_write) begin
                        write_req_d = 1'b1;
                        wdata_d     = head_cmd.data;
                    end else begin
                        read_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_resp) begin
                    read_req_d  = 1'b0;
                    write_req_d = 1'b0;
                    mem_done_d  = 1'b1;
                    if (read_req) datatoinst_d = lane_data;
                    state_d = GAP;
                end else if (TIMEOUT != 0 && (32'(wait_cnt) + 32'd1 == TIMEOUT)) begin
                    read_req_d  = 1'b0;
                    write_req_d = 1'b0;
                    mem_err_d   = 1'b1;
                    state_d     = GAP;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt + CW'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            read_req   <= 1'b0;
            write_req  <= 1'b0;
            mem_done   <= 1'b0;
            mem_err    <= 1'b0;
            addrout    <= '0;
            wdata      <= '0;
            datatoinst <= '0;
        end else begin
            state      <= state_d;
            wait_cnt   <= wait_cnt_d;
            read_req   <= read_req_d;
            write_req  <= write_req_d;
            mem_done   <= mem_done_d;
            mem_err    <= mem_err_d;
            addrout    <= addrout_d;
            wdata      <= wdata_d;
            datatoinst <= datatoinst_d;
        end
    end

endmodule

// File: tb/tb_mem_intf_ctrl.sv
// Directed, table-driven bench for mem_intf_ctrl (TIMEOUT=4, default widths).
module tb_mem_intf_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load, store, mem_resp;
    logic [13:0] addr;
    logic [15:0] result, rdata;
    logic        cmd_ready, mem_done, mem_err, read_req, write_req;
    logic [7:0]  datatoinst;
    logic [13:0] addrout;
    logic [15:0] wdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_intf_ctrl #(
        .ADDR_W(14), .MEM_W(16), .OP_W(8), .CMD_DEPTH(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .store(store),
        .addr(addr), .result(result), .cmd_ready(cmd_ready),
        .mem_done(mem_done), .mem_err(mem_err), .datatoinst(datatoinst),
        .read_req(read_req), .write_req(write_req), .addrout(addrout),
        .wdata(wdata), .rdata(rdata), .mem_resp(mem_resp)
    );

    typedef struct {
        logic [1:0]  ls;    // {load, store}
        logic [13:0] a;
        logic [15:0] res;
        logic        resp;
        logic [15:0] rd;
        logic [4:0]  flags; // {read_req, write_req, mem_done, mem_err, cmd_ready}
        logic [13:0] ao;
        logic [15:0] wd;
        logic [7:0]  dti;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [1:0] ls, input logic [13:0] a, input logic [15:0] res,
                       input logic resp, input logic [15:0] rd, input logic [4:0] flags,
                       input logic [13:0] ao, input logic [15:0] wd, input logic [7:0] dti);
        vec_t v;
        v.ls = ls; v.a = a; v.res = res; v.resp = resp; v.rd = rd;
        v.flags = flags; v.ao = ao; v.wd = wd; v.dti = dti;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] obs();
        return 64'({read_req, write_req, mem_done, mem_err, cmd_ready, addrout, wdata, datatoinst});
    endfunction

    task automatic step(input logic [1:0] ls, input logic [13:0] a, input logic [15:0] res,
                        input logic resp, input logic [15:0] rd);
        @(negedge clk);
        {load, store} = ls; addr = a; result = res; mem_resp = resp; rdata = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; store = 1'b0; mem_resp = 1'b0;
        addr = '0; result = '0; rdata = '0;

        // flags = {rr, wr, done, err, rdy}; outputs checked just after each edge
        add(2'b10, 14'h0005, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0000, 16'h0000, 8'h00);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0005, 16'h0000, 8'h00);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0005, 16'h0000, 8'h00);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0005, 16'h0000, 8'h00);
        add(2'b00, 14'h0000, 16'h0000, 1'b1, 16'hBEEF, 5'b00101, 14'h0005, 16'h0000, 8'hBE);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0005, 16'h0000, 8'hBE);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0005, 16'h0000, 8'hBE);
        add(2'b01, 14'h1FFE, 16'h1234, 1'b0, 16'h0000, 5'b00001, 14'h0005, 16'h0000, 8'hBE);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01001, 14'h1FFE, 16'h1234, 8'hBE);
        add(2'b10, 14'h0020, 16'h0000, 1'b1, 16'hAAAA, 5'b00101, 14'h1FFE, 16'h1234, 8'hBE);
        add(2'b10, 14'h0021, 16'h0000, 1'b0, 16'h0000, 5'b00000, 14'h1FFE, 16'h1234, 8'hBE);
        add(2'b10, 14'h0022, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0020, 16'h1234, 8'hBE);
        add(2'b10, 14'h0022, 16'h0000, 1'b0, 16'h0000, 5'b10000, 14'h0020, 16'h1234, 8'hBE);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10000, 14'h0020, 16'h1234, 8'hBE);
        add(2'b00, 14'h0000, 16'h0000, 1'b1, 16'h1357, 5'b00100, 14'h0020, 16'h1234, 8'h57);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 14'h0020, 16'h1234, 8'h57);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0021, 16'h1234, 8'h57);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0021, 16'h1234, 8'h57);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0021, 16'h1234, 8'h57);
        add(2'b00, 14'h0000, 16'h0000, 1'b1, 16'h2468, 5'b00101, 14'h0021, 16'h1234, 8'h24);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0021, 16'h1234, 8'h24);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0022, 16'h1234, 8'h24);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0022, 16'h1234, 8'h24);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10001, 14'h0022, 16'h1234, 8'h24);
        add(2'b00, 14'h0000, 16'h0000, 1'b1, 16'h9A5B, 5'b00101, 14'h0022, 16'h1234, 8'h5B);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0022, 16'h1234, 8'h5B);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0022, 16'h1234, 8'h5B);
        add(2'b11, 14'h0030, 16'hFFFF, 1'b0, 16'h0000, 5'b00011, 14'h0022, 16'h1234, 8'h5B);
        add(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00001, 14'h0022, 16'h1234, 8'h5B);
        add(2'b00, 14'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'b00001, 14'h0022, 16'h1234, 8'h5B);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), 64'({5'b00001, 14'h0000, 16'h0000, 8'h00}));
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].ls, vq[i].a, vq[i].res, vq[i].resp, vq[i].rd);
            check($sformatf("vec%0d", i), obs(),
                  64'({vq[i].flags, vq[i].ao, vq[i].wd, vq[i].dti}));
        end

        // Timeout: X (0x40) gets no response, Y (0x41) answers on the 4th edge.
        step(2'b10, 14'h0040, 16'h0000, 1'b0, 16'h0000);
        step(2'b10, 14'h0041, 16'h0000, 1'b0, 16'h0000);
        check("to_x_issued", 64'({read_req, addrout}), 64'({1'b1, 14'h0040}));
        repeat (3) step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        check("to_x_held", 64'({read_req, mem_err}), 64'({1'b1, 1'b0}));
        step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        check("to_x_fire", 64'({read_req, mem_err, mem_done, datatoinst}),
              64'({1'b0, 1'b1, 1'b0, 8'h5B}));
        step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        check("to_gap", 64'({read_req, mem_err}), 64'({1'b0, 1'b0}));
        step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        check("to_y_issued", 64'({read_req, addrout}), 64'({1'b1, 14'h0041}));
        repeat (3) step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        step(2'b00, 14'h0000, 16'h0000, 1'b1, 16'hC3A5);
        check("to_y_resp_wins", 64'({read_req, mem_done, mem_err, datatoinst}),
              64'({1'b0, 1'b1, 1'b0, 8'hC3}));

        // Reset mid-REQ with one entry still queued.
        step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        step(2'b10, 14'h0050, 16'h0000, 1'b0, 16'h0000);
        step(2'b10, 14'h0052, 16'h0000, 1'b0, 16'h0000);
        step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        check("rst_pre_req", 64'({read_req, addrout, cmd_ready}), 64'({1'b1, 14'h0050, 1'b1}));
        #2 reset_n = 1'b0;
        #1;
        check("rst_async", obs(), 64'({5'b00001, 14'h0000, 16'h0000, 8'h00}));
        @(negedge clk);
        reset_n = 1'b1;
        step(2'b00, 14'h0000, 16'h0000, 1'b1, 16'hFFFF);
        check("rst_late_resp", obs(), 64'({5'b00001, 14'h0000, 16'h0000, 8'h00}));
        step(2'b00, 14'h0000, 16'h0000, 1'b0, 16'h0000);
        check("rst_flushed", obs(), 64'({5'b00001, 14'h0000, 16'h0000, 8'h00}));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
